lsu_rmw: RTL

- CPU-side load/store unit; initiator for the word-only data memory (10-bit word address, single write enable, asynchronous read, write on posedge).
- Takes one load/store request from the MEM stage and drives the memory port.
- Performs byte/half extraction and sign extension for loads.
- Performs read-modify-write for sub-word stores, since the memory writes whole words only.
- Stalls the pipeline through `busy` until `done`.

---
 rtl/lsu_rmw_pkg.sv | 27 ++
 rtl/lsu_rmw_lane_merge.sv | 45 ++++
 rtl/lsu_rmw.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_rmw_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM encoding, window size.
// The optional unaligned LWL/LWR/SWL/SWR support is controlled by UNALIGNED_LR_EN.
package lsu_rmw_pkg;

  localparam int unsigned DM_BYTES_DEF = 4096;

  localparam logic [3:0] LSU_LW  = 4'd0;
  localparam logic [3:0] LSU_LH  = 4'd1;
  localparam logic [3:0] LSU_LHU = 4'd2;
  localparam logic [3:0] LSU_LB  = 4'd3;
  localparam logic [3:0] LSU_LBU = 4'd4;
  localparam logic [3:0] LSU_SW  = 4'd5;
  localparam logic [3:0] LSU_SH  = 4'd6;
  localparam logic [3:0] LSU_SB  = 4'd7;
  localparam logic [3:0] LSU_SWL = 4'd8;
  localparam logic [3:0] LSU_SWR = 4'd9;
  localparam logic [3:0] LSU_LWL = 4'd10;
  localparam logic [3:0] LSU_LWR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_rmw_lane_merge.sv
// Byte-lane steering: builds the merged store word and the extended load value.
// LWL/LWR/SWL/SWR lane handling exists only when UNALIGNED_LR_EN is defined.
module lsu_lane_merge
  import lsu_rmw_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  b,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [4:0]  sh_b;
  logic [4:0]  sh_nb;
  logic [15:0] half;
  logic [7:0]  byt;

  // sh_nb is the shift for (3-b) bytes, which is just the inverted lane index
  assign sh_b  = {b, 3'b000};
  assign sh_nb = {~b, 3'b000};
  assign half  = b[1] ? word[31:16] : word[15:0];
  assign byt   = 8'(word >> sh_b);

  always_comb begin
    st_word = wdata;
    ld_data = word;
    case (op)
      LSU_LH:  ld_data = {{16{half[15]}}, half};
      LSU_LHU: ld_data = {16'h0000, half};
      LSU_LB:  ld_data = {{24{byt[7]}}, byt};
      LSU_LBU: ld_data = {24'h000000, byt};
      LSU_SH:  st_word = b[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      LSU_SB:  st_word = (word & ~(32'h0000_00FF << sh_b)) | ({24'h000000, wdata[7:0]} << sh_b);
`ifdef UNALIGNED_LR_EN
      LSU_SWL: st_word = (word & ~(32'hFFFF_FFFF >> sh_nb)) | (wdata >> sh_nb);
      LSU_SWR: st_word = (word & ~(32'hFFFF_FFFF << sh_b)) | (wdata << sh_b);
      LSU_LWL: ld_data = (wdata & ~(32'hFFFF_FFFF << sh_nb)) | (word << sh_nb);
      LSU_LWR: ld_data = (wdata & ~(32'hFFFF_FFFF >> sh_b)) | (word >> sh_b);
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit driving a word-only data memory, with read-modify-write for sub-word stores.
// Define UNALIGNED_LR_EN to make LWL/LWR/SWL/SWR legal; otherwise they return err.
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter int unsigned DM_BYTES = DM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] merge_word;
  logic [31:0] st_word;
  logic [31:0] ld_data;
  logic [31:0] offs;
  logic        bad_req;

  function automatic logic op_legal(input logic [3:0] o);
    case (o)
      LSU_LW, LSU_LH, LSU_LHU, LSU_LB, LSU_LBU,
      LSU_SW, LSU_SH, LSU_SB: op_legal = 1'b1;
`ifdef UNALIGNED_LR_EN
      LSU_SWL, LSU_SWR, LSU_LWL, LSU_LWR: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] o, input logic [1:0] b);
    case (o)
      LSU_LW, LSU_SW:          misaligned = (b != 2'b00);
      LSU_LH, LSU_LHU, LSU_SH: misaligned = b[0];
      default:                 misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] o);
    case (o)
      LSU_LW, LSU_LH, LSU_LHU, LSU_LB, LSU_LBU, LSU_LWL, LSU_LWR: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  assign offs    = addr - DM_BASE;
  assign bad_req = !op_legal(op) || misaligned(op, addr[1:0]) || (offs >= 32'(DM_BYTES));

  // In RD the memory word is consumed straight off the async read port
  assign merge_word = (state_q == ST_RD) ? mem_dout : word_q;

  lsu_lane_merge u_merge (
    .op      (op_q),
    .b       (addr_q[1:0]),
    .word    (merge_word),
    .wdata   (wdata_q),
    .st_word (st_word),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr[11:0];
          wdata_d = wdata;
          err_d   = bad_req;
          if (bad_req) begin
            state_d = ST_RSP;
            rdata_d = '0;
          end else if (op == LSU_SW) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        word_d = mem_dout;
        if (is_load(op_q)) begin
          state_d = ST_RSP;
          rdata_d = ld_data;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        state_d = ST_RSP;
        rdata_d = '0;
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    wdata_q <= wdata_d;
    word_q  <= word_d;
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_RSP);
  assign err      = done & err_q;
  assign rdata    = rdata_q;
  assign mem_addr = addr_q[11:2];
  assign mem_we   = (state_q == ST_WR) & ~reset;
  assign mem_din  = (state_q == ST_WR) ? st_word : '0;

endmodule
